blob_frame_streamer: RTL and testbench



---
 rtl/blob_frame_streamer.sv | 162 ++++++++++++++++
 tb/tb_blob_frame_streamer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/blob_frame_streamer.sv
// blob_frame_streamer
//
// Captures one camera frame, thresholds each RGB pixel to a single bit,
// stores the bitmap in an N x 1 on-chip RAM and replays it on request as
// an uninterrupted raster stream of exactly ROWS*COLS valid cycles.
//
// Ports:
//   i_clk        system clock, all logic on the rising edge
//   i_rst        synchronous active-high reset
//   i_capture    arm request: capture the next frame
//   i_sof        start-of-frame strobe (one cycle)
//   i_pix_valid  pixel strobe, i_r/i_g/i_b valid this cycle
//   i_r/i_g/i_b  pixel colour components, PIX_W bits each
//   i_threshold  luma threshold, sampled with each pixel
//   i_start      request to stream the stored frame
//   o_valid      stream valid
//   o_seq        stream bit (0 outside the streaming window)
//   o_full       a complete frame is stored and ready to stream
//   o_done       one-cycle pulse after the last streamed bit
module blob_frame_streamer #(
    parameter int ROWS   = 480,
    parameter int COLS   = 640,
    parameter int PIX_W  = 12,
    parameter int INVERT = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_capture,
    input  logic             i_sof,
    input  logic             i_pix_valid,
    input  logic [PIX_W-1:0] i_r,
    input  logic [PIX_W-1:0] i_g,
    input  logic [PIX_W-1:0] i_b,
    input  logic [PIX_W-1:0] i_threshold,
    input  logic             i_start,
    output logic             o_valid,
    output logic             o_seq,
    output logic             o_full,
    output logic             o_done
);

    localparam int            N    = ROWS * COLS;
    localparam int            AW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] LAST = AW'(N - 1);
    localparam logic          INV  = (INVERT != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_FULL,
        S_STREAM
    } state_t;

    state_t        state;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          last_issued;
    logic          ram_q;
    logic          mem [N];

    // Binarize: luma = (R + 2G + B) / 4, computed two bits wide so the sum
    // of three full-scale components never wraps.
    logic [PIX_W+1:0] sum;
    logic [PIX_W-1:0] luma;
    logic             pix_bit;

    assign sum     = {2'b00, i_r} + {1'b0, i_g, 1'b0} + {2'b00, i_b};
    assign luma    = sum[PIX_W+1:2];
    assign pix_bit = (luma >= i_threshold) ^ INV;

    // Write-port decode. An i_sof (from ARMED, or mid-frame as a resync)
    // forces this cycle's pixel to address 0.
    logic          capturing;
    logic          wr_en;
    logic [AW-1:0] wr_ptr;

    // NOTE: every always_comb output gets a value on every path, otherwise
    // synthesis infers a latch to hold the old value.
    always_comb begin
        capturing = (state == S_CAPTURE) || ((state == S_ARMED) && i_sof);
        wr_en     = capturing && i_pix_valid;
        wr_ptr    = i_sof ? '0 : wr_addr;
    end

    // Bitmap RAM with a registered read port so it maps onto block RAM.
    // NOTE: the memory array has no reset; clearing it would block RAM
    // inference, and a stale bitmap is unreachable because S_FULL is only
    // entered through a complete capture.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= pix_bit;
        end
        ram_q <= mem[rd_addr];
    end

    // Stream bit is the registered RAM output, gated so it reads 0 outside
    // the streaming window.
    assign o_seq = o_valid & ram_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            wr_addr     <= '0;
            rd_addr     <= '0;
            o_full      <= 1'b0;
            o_valid     <= 1'b0;
            o_done      <= 1'b0;
            last_issued <= 1'b0;
        end else begin
            // Read data for the address issued this cycle lands next cycle,
            // so valid and done trail the read pointer by one and two cycles.
            o_valid     <= (state == S_STREAM);
            last_issued <= (state == S_STREAM) && (rd_addr == LAST);
            o_done      <= last_issued;

            case (state)
                S_IDLE: begin
                    if (i_capture) begin
                        state <= S_ARMED;
                    end
                end

                S_ARMED, S_CAPTURE: begin
                    if (capturing) begin
                        if (wr_en && (wr_ptr == LAST)) begin
                            state   <= S_FULL;
                            o_full  <= 1'b1;
                            wr_addr <= '0;
                        end else begin
                            state   <= S_CAPTURE;
                            wr_addr <= wr_en ? wr_ptr + 1'b1 : wr_ptr;
                        end
                    end
                end

                S_FULL: begin
                    // i_start takes priority; i_capture is ignored here.
                    if (i_start) begin
                        state   <= S_STREAM;
                        rd_addr <= '0;
                        o_full  <= 1'b0;
                    end
                end

                S_STREAM: begin
                    if (rd_addr == LAST) begin
                        state   <= S_IDLE;
                        rd_addr <= '0;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blob_frame_streamer.sv
// Directed testbench for blob_frame_streamer at ROWS=4, COLS=8.
// Two instances share all inputs: one with INVERT=0, one with INVERT=1,
// so every streamed frame is also checked in complemented form.
module tb_blob_frame_streamer;

    localparam int ROWS  = 4;
    localparam int COLS  = 8;
    localparam int N     = ROWS * COLS;
    localparam int PIX_W = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             capture;
    logic             sof;
    logic             pix_valid;
    logic [PIX_W-1:0] r, g, b, thr;
    logic             start;

    logic valid, seq, full, done;
    logic valid_inv, seq_inv, full_inv, done_inv;

    always #5 clk = ~clk;

    blob_frame_streamer #(.ROWS(ROWS), .COLS(COLS), .PIX_W(PIX_W), .INVERT(0)) dut (
        .i_clk(clk), .i_rst(rst), .i_capture(capture), .i_sof(sof),
        .i_pix_valid(pix_valid), .i_r(r), .i_g(g), .i_b(b),
        .i_threshold(thr), .i_start(start),
        .o_valid(valid), .o_seq(seq), .o_full(full), .o_done(done)
    );

    blob_frame_streamer #(.ROWS(ROWS), .COLS(COLS), .PIX_W(PIX_W), .INVERT(1)) dut_inv (
        .i_clk(clk), .i_rst(rst), .i_capture(capture), .i_sof(sof),
        .i_pix_valid(pix_valid), .i_r(r), .i_g(g), .i_b(b),
        .i_threshold(thr), .i_start(start),
        .o_valid(valid_inv), .o_seq(seq_inv), .o_full(full_inv), .o_done(done_inv)
    );

    int n_asserts = 0;
    int n_fails   = 0;

    logic [PIX_W-1:0] fr_r [N];
    logic [PIX_W-1:0] fr_g [N];
    logic [PIX_W-1:0] fr_b [N];
    logic [PIX_W-1:0] fr_t [N];
    logic             exp_bits [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled and inputs driven 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pixel(input int k);
        r = fr_r[k]; g = fr_g[k]; b = fr_b[k]; thr = fr_t[k];
    endtask

    // Arm, then deliver the frame arrays with random 0-3 idle cycles between
    // strobes. i_sof is either its own cycle or coincident with pixel 0.
    task automatic capture_frame(input bit sof_with_first);
        int gap;
        capture = 1'b1; tick(); capture = 1'b0;
        if (!sof_with_first) begin
            sof = 1'b1; tick(); sof = 1'b0;
        end
        for (int k = 0; k < N; k++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) tick();
            if (k == N - 1) check("full_before_last", full, 0);
            sof       = sof_with_first && (k == 0);
            set_pixel(k);
            pix_valid = 1'b1;
            tick();
            pix_valid = 1'b0;
            sof       = 1'b0;
        end
        check("full_after_last", full, 1);
        check("full_after_last_inv", full_inv, 1);
    endtask

    // Pulse i_start (with i_capture, which must lose) and check the whole stream.
    task automatic stream_frame(input string tag);
        start = 1'b1; capture = 1'b1; tick(); start = 1'b0; capture = 1'b0;
        check({tag, "_full_fall"}, full, 0);
        check({tag, "_valid_t1"}, valid, 0);
        tick();
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s_valid%0d", tag, k), valid, 1);
            check($sformatf("%s_seq%0d", tag, k), seq, exp_bits[k]);
            check($sformatf("%s_seq_inv%0d", tag, k), seq_inv, !exp_bits[k]);
            if (k == 0) check({tag, "_valid_inv0"}, valid_inv, 1);
            if (k == N - 1) check({tag, "_done_early"}, done, 0);
            tick();
        end
        check({tag, "_valid_end"}, valid, 0);
        check({tag, "_seq_end"}, seq, 0);
        check({tag, "_done"}, done, 1);
        check({tag, "_done_inv"}, done_inv, 1);
        tick();
        check({tag, "_done_fall"}, done, 0);
    endtask

    task automatic fill_checkerboard();
        for (int k = 0; k < N; k++) begin
            fr_r[k] = (k % 2 == 0) ? 12'd4095 : 12'd0;
            fr_g[k] = fr_r[k];
            fr_b[k] = fr_r[k];
            fr_t[k] = 12'd2048;
            exp_bits[k] = (k % 2 == 0);
        end
    endtask

    task automatic set_px(input int k, input int rr, input int gg, input int bb, input int tt,
                          input logic e);
        fr_r[k] = PIX_W'(rr); fr_g[k] = PIX_W'(gg); fr_b[k] = PIX_W'(bb);
        fr_t[k] = PIX_W'(tt); exp_bits[k] = e;
    endtask

    initial begin
        bit saw_valid;

        rst = 1'b1; capture = 1'b0; sof = 1'b0; pix_valid = 1'b0;
        r = '0; g = '0; b = '0; thr = '0; start = 1'b0;

        // Reset values
        tick(); tick();
        check("rst_valid", valid, 0);
        check("rst_seq", seq, 0);
        check("rst_full", full, 0);
        check("rst_done", done, 0);
        rst = 1'b0;

        // Pixel burst without arming: nothing is captured
        sof = 1'b1; r = 12'd4095; g = 12'd4095; b = 12'd4095; thr = 12'd2048;
        for (int k = 0; k < 40; k++) begin
            pix_valid = 1'b1; tick(); sof = 1'b0;
        end
        pix_valid = 1'b0;
        tick();
        check("burst_no_capture_full", full, 0);
        check("burst_no_capture_valid", valid, 0);

        // Checkerboard; pixels, i_sof and i_capture in S_FULL are ignored
        fill_checkerboard();
        capture_frame(1'b0);
        capture = 1'b1; sof = 1'b1; pix_valid = 1'b1;
        r = 12'd0; g = 12'd0; b = 12'd0;
        repeat (3) begin tick(); sof = 1'b0; end
        capture = 1'b0; pix_valid = 1'b0;
        check("full_holds", full, 1);
        stream_frame("checker");

        // No replay from S_IDLE
        start = 1'b1; tick(); start = 1'b0;
        saw_valid = 1'b0;
        repeat (N + 4) begin saw_valid |= valid; tick(); end
        check("no_replay_valid", saw_valid, 0);
        check("no_replay_full", full, 0);

        // Threshold boundaries, i_sof coincident with pixel 0 in S_ARMED
        for (int k = 0; k < N; k++) set_px(k, 0, 0, 0, 1, 1'b0);
        set_px(0, 2048, 2048, 2048, 2048, 1'b1);   // luma 2048 >= 2048
        set_px(1, 2048, 2048, 2048, 2049, 1'b0);   // luma 2048 <  2049
        set_px(2, 4095, 4095, 4095, 4095, 1'b1);   // luma 4095, no wrap
        set_px(3, 4095, 0, 0, 1023, 1'b1);         // sum 4095 -> luma 1023
        set_px(4, 4095, 0, 0, 1024, 1'b0);
        set_px(5, 0, 4095, 0, 2047, 1'b1);         // green counted twice: 2047
        set_px(6, 0, 4095, 0, 2048, 1'b0);
        set_px(7, 1, 1, 2, 1, 1'b1);               // sum 5 -> luma 1
        set_px(8, 1, 1, 1, 2, 1'b0);               // sum 4 -> luma 1
        set_px(N - 1, 0, 0, 0, 0, 1'b1);           // 0 >= 0
        capture_frame(1'b1);
        stream_frame("thresh");

        // Mid-frame resync: ten bright pixels, then i_sof with 32 dark pixels
        capture = 1'b1; tick(); capture = 1'b0;
        sof = 1'b1; tick(); sof = 1'b0;
        r = 12'd4095; g = 12'd4095; b = 12'd4095; thr = 12'd2048;
        for (int k = 0; k < 10; k++) begin
            pix_valid = 1'b1; tick(); pix_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        r = 12'd0; g = 12'd0; b = 12'd0;
        for (int k = 0; k < N; k++) begin
            if (k == N - 1) check("resync_full_before_last", full, 0);
            sof = (k == 0); pix_valid = 1'b1; tick(); pix_valid = 1'b0; sof = 1'b0;
        end
        check("resync_full_after_last", full, 1);
        for (int k = 0; k < N; k++) exp_bits[k] = 1'b0;
        stream_frame("resync");

        // Reset at stream bit 13
        fill_checkerboard();
        capture_frame(1'b0);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        for (int k = 0; k < 13; k++) begin
            check($sformatf("midrst_seq%0d", k), seq, exp_bits[k]);
            tick();
        end
        check("midrst_valid13", valid, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrst_valid", valid, 0);
        check("midrst_seq", seq, 0);
        check("midrst_full", full, 0);
        check("midrst_done", done, 0);
        start = 1'b1; tick(); start = 1'b0;
        saw_valid = 1'b0;
        repeat (N + 4) begin saw_valid |= valid | done; tick(); end
        check("midrst_no_stream", saw_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
